tt_um_cam_ol2: RTL and testbench
================================

# tt_um_cam_ol2

8-entry, 8-bit-key content-addressable memory packaged as a TinyTapeout user module. It is the consumer of the 8-bit key stream on the bidirectional bus. For bring-up, the factory-test counter's uio output drives `uio_in`, so the CAM can be exercised with a free-running key source. Commands arrive on `ui_in`, keys on `uio_in`, and results and status leave on `uo_out`.

## Interface
- Parameters: none at top level. Localparams are `ENTRIES` = 8 (entry count) and `KEY_W` = 8 (key width).
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous, active-low. Assertion takes effect immediately. Deassertion is registered through one flop (internal `rst_n_i`) before state leaves reset.
- `ui_in`  in  8  command bus:
  - [7] `cmd_valid`; a command is taken on its rising edge.
  - [6:5] `op`.
  - [2:0] `idx`.
  - [4:3] reserved, ignored.
- `uo_out`  out  8  status and results:
  - [2:0] `match_idx`.
  - [3] `hit`.
  - [4] `multi`.
  - [5] `done`.
  - [6] `busy`.
  - [7] `dropped`.
- `uio_in`  in  8  key / write data.
- `uio_out`  out  8  constant 0.
- `uio_oe`  out  8  constant 0; all uio pins are inputs.
- `ena`  in  1  ignored.

## Operation
- **Storage:** 8 × (8-bit key + valid bit).
- **Reset values:** all keys 0, all valid 0, all `uo_out` bits 0, FSM in IDLE.
- **Edge detect:** `cmd_prev` holds `ui_in[7]` registered. A command is accepted in cycle N when `ui_in[7]`=1, `cmd_prev`=0 and `busy`=0. On acceptance, `op`, `idx` and `uio_in` are latched.
- **Dropped commands:** a rising edge while `busy`=1 is discarded and sets `dropped`. `dropped` is sticky and is cleared only by reset or by an accepted CLEAR_ALL.
- **Opcodes:**
  - 00 WRITE: entry[`idx`].key <= key, valid <= 1. An existing identical key elsewhere is not checked.
  - 01 INVAL: entry[`idx`].valid <= 0. Key contents are retained.
  - 10 SEARCH: compare the key against all valid entries in parallel.
    - `hit` = any match.
    - `match_idx` = lowest matching index, or 0 if there is no hit.
    - `multi` = two or more matches.
  - 11 CLEAR_ALL: clears valid bits sequentially, one entry per cycle, index 0 to 7.
- **FSM states:** IDLE, SRCH_CMP, SRCH_ENC, SWEEP.
  - IDLE goes to SRCH_CMP on an accepted SEARCH, or to SWEEP (counter = 0) on an accepted CLEAR_ALL. WRITE and INVAL complete from IDLE.
  - SRCH_CMP registers the 8-bit match vector, then moves to SRCH_ENC.
  - SRCH_ENC registers the encoder output into `hit`, `match_idx` and `multi`, then moves to IDLE.
  - SWEEP clears valid[counter] each cycle. The counter wraps at 7, after which the FSM moves to IDLE.
- `hit`, `match_idx` and `multi` change only at SEARCH completion. They hold their value through WRITE, INVAL and CLEAR_ALL.
- `done` is a single-cycle pulse at the completion of every accepted command.
- **Compare snapshot:** SEARCH compares against entry contents as they stand at the SRCH_CMP edge. No write can intervene, because `busy` blocks acceptance.

## Timing
- Acceptance cycle is N. All outputs are registered.
- **WRITE / INVAL:** entry updated at edge N+1 and `done`=1 in cycle N+1. `busy` stays 0.
- **SEARCH:** `busy`=1 in N+1 and N+2. Results are valid and `done`=1 in N+2. `busy`=0 in N+3.
- **CLEAR_ALL:**
  - `busy`=1 in N+1 through N+8.
  - valid[i] is cleared at the end of cycle N+1+i.
  - `done`=1 in N+8.
  - `dropped` clears at N+1.
- **Command spacing:** the minimum spacing between accepted commands is 2 cycles, because a rising edge requires a low cycle first.
- **Held `cmd_valid`:** `cmd_valid` held high through `busy` does not generate a new command when `busy` falls.
- **Reset mid-operation:** asynchronously aborts any SEARCH or SWEEP. All entries invalid, FSM IDLE, outputs 0. The first command is accepted no earlier than the second rising clk after `rst_n` deasserts.

## Structure
- `cam_pkg` holds:
  - `ENTRIES`, `KEY_W`, `IDX_W` = 3.
  - Opcode constants `OP_WRITE`, `OP_INVAL`, `OP_SEARCH`, `OP_CLEAR`.
  - FSM state encodings.
  - `uo_out` bit-position constants.
- Sub-module `cam_prio_enc`: combinational, 8-bit match vector in; `hit`, `multi` and 3-bit lowest-set index out. Instantiated once, with its outputs registered in SRCH_ENC.
- The top holds the storage, edge detect, FSM, sweep counter and `dropped` flag.

## Test plan
- **Reset:** assert `rst_n` mid-SEARCH -> `uo_out`=0x00 immediately. After release, SEARCH 0x00 gives `hit`=0 (no valid entries despite keys = 0).
- **Write and search:** WRITE idx3 key 0xA5, then SEARCH 0xA5 -> `uo_out`[3:0]=0xB (`hit`=1, idx=3) and `done` in N+2. SEARCH 0x5A gives `hit`=0, idx=0.
- **Multi-hit and invalidate:** WRITE 0x3C to idx 6 and idx 1, then SEARCH 0x3C -> `hit`=1, `multi`=1, idx=1. INVAL idx1 and SEARCH again -> `multi`=0, idx=6.
- **Drop and sweep:** toggle `cmd_valid` during a CLEAR_ALL sweep -> `dropped`=1, entry unchanged. Sweep `done` occurs 8 cycles after acceptance. A subsequent CLEAR_ALL clears `dropped`.
- **Bring-up stream:** drive `uio_in` from an incrementing counter and issue SEARCH every 4 cycles with 0x10 stored at idx 7 -> exactly one `hit` result, when the latched key = 0x10.
- **Held valid:** hold `ui_in[7]` high for 20 cycles -> exactly one command accepted and one `done` pulse.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and types for the 8-entry CAM: sizes, opcodes,
// FSM encodings and uo_out bit positions.
package cam_pkg;
    localparam int ENTRIES = 8;
    localparam int KEY_W   = 8;
    localparam int IDX_W   = 3;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_INVAL  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SRCH_CMP = 2'd1,
        ST_SRCH_ENC = 2'd2,
        ST_SWEEP    = 2'd3
    } state_t;

    localparam int UO_IDX_LSB = 0;
    localparam int UO_HIT     = 3;
    localparam int UO_MULTI   = 4;
    localparam int UO_DONE    = 5;
    localparam int UO_BUSY    = 6;
    localparam int UO_DROPPED = 7;
endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over the CAM match vector, with
// any-hit and two-or-more-hit flags.
module cam_prio_enc
    import cam_pkg::*;
(
    input  logic [ENTRIES-1:0] match_vec,
    output logic               hit,
    output logic               multi,
    output logic [IDX_W-1:0]   idx
);
    always_comb begin
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) idx = IDX_W'(i);
        end
    end

    assign hit = |match_vec;
    // clearing the lowest set bit leaves something only if two or more were set
    assign multi = |(match_vec & (match_vec - ENTRIES'(1)));
endmodule

// File: rtl/tt_um_cam_ol2.sv
// 8-entry x 8-bit CAM TinyTapeout wrapper: command edge detect, storage,
// search pipeline, sequential clear sweep and sticky drop flag.
//
// state       | meaning
// ST_IDLE     | waiting for a command; WRITE/INVAL complete here
// ST_SRCH_CMP | match vector registered, encoder result being captured
// ST_SRCH_ENC | search results and done presented
// ST_SWEEP    | clearing valid[sweep_cnt], one entry per cycle
module tt_um_cam_ol2
    import cam_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    logic               rst_n_i;
    logic               cmd_prev;
    state_t             state, state_nxt;
    logic [KEY_W-1:0]   keys [ENTRIES];
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] match_now, match_q;
    logic [IDX_W-1:0]   sweep_cnt;
    logic               hit_q, multi_q, done_q, dropped_q;
    logic [IDX_W-1:0]   idx_q;
    logic               enc_hit, enc_multi;
    logic [IDX_W-1:0]   enc_idx;
    logic               busy, enc_load, sweep_en, rise, accept;
    logic [1:0]         op;
    logic [IDX_W-1:0]   cmd_idx;
    logic               unused;

    assign op      = ui_in[6:5];
    assign cmd_idx = ui_in[2:0];
    assign unused  = &{1'b0, ena, ui_in[4:3]};
    assign uio_out = '0;
    assign uio_oe  = '0;

    // gating acceptance on rst_n_i keeps the first post-reset edge inert
    assign rise   = ui_in[7] & ~cmd_prev;
    assign accept = rise & ~busy & rst_n_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_n_i  <= 1'b0;
            cmd_prev <= 1'b0;
        end else begin
            rst_n_i  <= 1'b1;
            cmd_prev <= ui_in[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && op == OP_SEARCH)     state_nxt = ST_SRCH_CMP;
                else if (accept && op == OP_CLEAR) state_nxt = ST_SWEEP;
            end
            ST_SRCH_CMP: state_nxt = ST_SRCH_ENC;
            ST_SRCH_ENC: state_nxt = ST_IDLE;
            ST_SWEEP: begin
                if (sweep_cnt == IDX_W'(ENTRIES - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        enc_load = (state == ST_SRCH_CMP);
        sweep_en = (state == ST_SWEEP);
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            match_now[i] = valid[i] && (keys[i] == uio_in);
        end
    end

    cam_prio_enc u_enc (
        .match_vec (match_q),
        .hit       (enc_hit),
        .multi     (enc_multi),
        .idx       (enc_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys  <= '{default: '0};
            valid <= '0;
        end else begin
            if (accept && op == OP_WRITE) begin
                keys[cmd_idx]  <= uio_in;
                valid[cmd_idx] <= 1'b1;
            end
            if (accept && op == OP_INVAL) valid[cmd_idx] <= 1'b0;
            if (sweep_en) valid[sweep_cnt] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q   <= '0;
            sweep_cnt <= '0;
            hit_q     <= 1'b0;
            multi_q   <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            // the snapshot is taken on the accepting edge, so no write can slip in
            if (accept && op == OP_SEARCH) match_q <= match_now;
            if (accept && op == OP_CLEAR) sweep_cnt <= '0;
            else if (sweep_en)             sweep_cnt <= sweep_cnt + IDX_W'(1);
            if (enc_load) begin
                hit_q   <= enc_hit;
                multi_q <= enc_multi;
                idx_q   <= enc_idx;
            end
            // the sweep's done lines up with its last clearing cycle
            done_q <= (accept && (op == OP_WRITE || op == OP_INVAL)) || enc_load ||
                      (sweep_en && sweep_cnt == IDX_W'(ENTRIES - 2));
            if (accept && op == OP_CLEAR) dropped_q <= 1'b0;
            else if (rise && busy)         dropped_q <= 1'b1;
        end
    end

    always_comb begin
        uo_out = '0;
        uo_out[UO_IDX_LSB +: IDX_W] = idx_q;
        uo_out[UO_HIT]     = hit_q;
        uo_out[UO_MULTI]   = multi_q;
        uo_out[UO_DONE]    = done_q;
        uo_out[UO_BUSY]    = busy;
        uo_out[UO_DROPPED] = dropped_q;
    end
endmodule

// File: tb/tb_tt_um_cam_ol2.sv
// Self-checking bench for tt_um_cam_ol2: a reference model pushes the expected
// result fields for every command; a monitor pops and compares on each done.
module tb_tt_um_cam_ol2;
    import cam_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

    int errors = 0;
    int checks = 0;

    logic [7:0] mkey   [8];
    logic       mvalid [8];
    logic [4:0] last_res;
    logic [4:0] sb [$];

    tt_um_cam_ol2 dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model_search(input logic [7:0] k);
        logic [2:0] idx;
        int         n;
        idx = 3'd0;
        n   = 0;
        for (int i = 7; i >= 0; i--) begin
            if (mvalid[i] && mkey[i] == k) begin
                idx = 3'(i);
                n++;
            end
        end
        return {n > 1, n > 0, idx};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mkey[i]   = 8'h00;
            mvalid[i] = 1'b0;
        end
        last_res = 5'd0;
    endtask

    task automatic push_expect(input logic [1:0] op, input logic [2:0] idx, input logic [7:0] key);
        case (op)
            OP_WRITE: begin
                mkey[idx]   = key;
                mvalid[idx] = 1'b1;
            end
            OP_INVAL:  mvalid[idx] = 1'b0;
            OP_SEARCH: last_res = model_search(key);
            default:   for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        endcase
        sb.push_back(last_res);
    endtask

    // Scoreboard monitor: every done pulse must match a queued command.
    always @(negedge clk) begin
        if (rst_n && uo_out[5]) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: uo_out=%h with no command pending", uo_out);
            end else begin
                logic [4:0] exp;
                exp = sb.pop_front();
                if (uo_out[4:0] !== exp) begin
                    errors++;
                    $display("FAIL result: got {multi,hit,idx}=%b expected %b", uo_out[4:0], exp);
                end
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] idx,
                          input logic [7:0] key, input int exp_lat);
        int   lat;
        logic got;
        @(negedge clk);
        push_expect(op, idx, key);
        ui_in  = {1'b1, op, 2'b00, idx};
        uio_in = key;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            ui_in[7] = 1'b0;
            if (lat == 1) begin
                checks++;
                if (uo_out[6] !== (op == OP_SEARCH || op == OP_CLEAR)) begin
                    errors++;
                    $display("FAIL busy_first_cycle op=%0d: got %b", op, uo_out[6]);
                end
            end
            if (uo_out[5]) got = 1'b1;
        end
        checks++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL latency op=%0d: got %0d (seen=%b) expected %0d", op, lat, got, exp_lat);
        end
        @(negedge clk);
        checks++;
        if (uo_out[6] !== 1'b0 || uo_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after op=%0d: busy=%b done=%b expected 0 0", op, uo_out[6], uo_out[5]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: got %h expected 00", uo_out);
        end
        rst_n = 1'b1;
        model_reset();
        do_cmd(OP_WRITE, 3'd2, 8'h00, 1);
        @(negedge clk);
        push_expect(OP_SEARCH, 3'd0, 8'h00);
        ui_in  = {1'b1, OP_SEARCH, 2'b00, 3'd0};
        uio_in = 8'h00;
        @(negedge clk);
        ui_in[7] = 1'b0;
        checks++;
        if (uo_out[6] !== 1'b1) begin
            errors++;
            $display("FAIL mid_search_busy: got %b expected 1", uo_out[6]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %h expected 00", uo_out);
        end
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_cmd(OP_SEARCH, 3'd0, 8'h00, 2);
        checks++;
        if (uo_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_search_hit: got %b expected 0", uo_out[3]);
        end
    endtask

    task automatic test_write_search();
        do_cmd(OP_WRITE, 3'd3, 8'hA5, 1);
        do_cmd(OP_SEARCH, 3'd0, 8'hA5, 2);
        checks++;
        if (uo_out[3:0] !== 4'hB) begin
            errors++;
            $display("FAIL search_a5: got %h expected b", uo_out[3:0]);
        end
        do_cmd(OP_SEARCH, 3'd0, 8'h5A, 2);
        checks++;
        if (uo_out[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL search_5a: got %h expected 0", uo_out[3:0]);
        end
    endtask

    task automatic test_multi_inval();
        do_cmd(OP_WRITE, 3'd6, 8'h3C, 1);
        do_cmd(OP_WRITE, 3'd1, 8'h3C, 1);
        do_cmd(OP_SEARCH, 3'd0, 8'h3C, 2);
        checks++;
        if (uo_out[4:0] !== 5'b11001) begin
            errors++;
            $display("FAIL multi_hit: got %b expected 11001", uo_out[4:0]);
        end
        do_cmd(OP_INVAL, 3'd1, 8'h00, 1);
        do_cmd(OP_SEARCH, 3'd0, 8'h3C, 2);
        checks++;
        if (uo_out[4:0] !== 5'b01110) begin
            errors++;
            $display("FAIL after_inval: got %b expected 01110", uo_out[4:0]);
        end
    endtask

    task automatic test_drop_sweep();
        int   lat;
        logic got;
        do_cmd(OP_WRITE, 3'd4, 8'h44, 1);
        @(negedge clk);
        push_expect(OP_CLEAR, 3'd0, 8'h00);
        ui_in = {1'b1, OP_CLEAR, 2'b00, 3'd0};
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (uo_out[5]) got = 1'b1;
            case (lat)
                1: ui_in[7] = 1'b0;
                3: begin
                    ui_in  = {1'b1, OP_WRITE, 2'b00, 3'd0};
                    uio_in = 8'h99;
                end
                4: ui_in[7] = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (!got || lat != 8) begin
            errors++;
            $display("FAIL sweep_latency: got %0d (seen=%b) expected 8", lat, got);
        end
        @(negedge clk);
        checks++;
        if (uo_out[7] !== 1'b1 || uo_out[6] !== 1'b0) begin
            errors++;
            $display("FAIL dropped_set: dropped=%b busy=%b expected 1 0", uo_out[7], uo_out[6]);
        end
        do_cmd(OP_SEARCH, 3'd0, 8'h99, 2);
        do_cmd(OP_SEARCH, 3'd0, 8'h44, 2);
        checks++;
        if (uo_out[7] !== 1'b1) begin
            errors++;
            $display("FAIL dropped_sticky: got %b expected 1", uo_out[7]);
        end
        do_cmd(OP_CLEAR, 3'd0, 8'h00, 8);
        checks++;
        if (uo_out[7] !== 1'b0) begin
            errors++;
            $display("FAIL dropped_clear: got %b expected 0", uo_out[7]);
        end
    endtask

    task automatic test_stream();
        int hits;
        hits = 0;
        do_cmd(OP_WRITE, 3'd7, 8'h10, 1);
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            if (uo_out[5] && uo_out[3]) hits++;
            uio_in = 8'(c);
            if (c % 4 == 0 && c < 256) begin
                ui_in = {1'b1, OP_SEARCH, 2'b00, 3'd0};
                push_expect(OP_SEARCH, 3'd0, 8'(c));
            end else begin
                ui_in[7] = 1'b0;
            end
        end
        checks++;
        if (hits != 1) begin
            errors++;
            $display("FAIL stream_hits: got %0d expected 1", hits);
        end
    endtask

    task automatic test_held();
        int dones;
        dones = 0;
        @(negedge clk);
        push_expect(OP_SEARCH, 3'd0, 8'h10);
        ui_in  = {1'b1, OP_SEARCH, 2'b00, 3'd0};
        uio_in = 8'h10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uo_out[5]) dones++;
        end
        ui_in[7] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (uo_out[5]) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL held_valid_dones: got %0d expected 1", dones);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        test_reset();
        test_write_search();
        test_multi_inval();
        test_drop_sweep();
        test_stream();
        test_held();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
